// File: rtl/gc_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  gc_input_conditioner_if
//  Receiver-side button/stick levels and conditioned game events.
//  Revision: 1.0
// ============================================================================
interface gc_input_conditioner_if;
    logic       A;
    logic       B;
    logic       X;
    logic       Y;
    logic       start_pause;
    logic       Z;
    logic       D_UP;
    logic       D_DOWN;
    logic       D_LEFT;
    logic       D_RIGHT;
    logic [7:0] JOY_X;
    logic [7:0] JOY_Y;
    logic [5:0] btn_held;
    logic [5:0] btn_press;
    logic [3:0] dir_held;
    logic [3:0] dir_pulse;

    modport master (
        output A, B, X, Y, start_pause, Z,
        output D_UP, D_DOWN, D_LEFT, D_RIGHT,
        output JOY_X, JOY_Y,
        input  btn_held, btn_press, dir_held, dir_pulse
    );

    modport slave (
        input  A, B, X, Y, start_pause, Z,
        input  D_UP, D_DOWN, D_LEFT, D_RIGHT,
        input  JOY_X, JOY_Y,
        output btn_held, btn_press, dir_held, dir_pulse
    );
endinterface
`default_nettype wire

// File: rtl/gc_input_conditioner.sv
`default_nettype none
// ============================================================================
//  gc_input_conditioner
//  Button press pulses, hysteretic stick/D-pad direction merge, auto-repeat.
//  Revision: 1.0
// ============================================================================
module gc_input_conditioner #(
    parameter int TICK_CYCLES  = 100000,
    parameter int DEADZONE_ON  = 40,
    parameter int DEADZONE_OFF = 24,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    gc_input_conditioner_if.slave  gc
);

    localparam int c_tick_w  = $clog2((TICK_CYCLES > 1) ? TICK_CYCLES : 2);
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_cnt_w   = $clog2(c_rep_max + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_delay     = c_cnt_w'(REPEAT_DELAY);
    localparam logic [c_cnt_w-1:0]  c_rate      = c_cnt_w'(REPEAT_RATE);

    localparam logic [8:0] c_center = 9'd128;
    localparam logic [8:0] c_on     = 9'(DEADZONE_ON);
    localparam logic [8:0] c_off    = 9'(DEADZONE_OFF);
    localparam logic [8:0] c_hi_on  = c_center + c_on;
    localparam logic [8:0] c_hi_off = c_center + c_off;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } dir_state_t;

    function automatic logic hyst(input logic cur, input logic set_c, input logic clr_c);
        if (set_c) return 1'b1;
        if (clr_c) return 1'b0;
        return cur;
    endfunction

    logic [5:0] w_buttons;
    logic [3:0] w_dpad;
    logic [5:0] r_btn_held;
    logic [5:0] r_btn_prev;
    logic [5:0] r_btn_press;
    logic [3:0] r_dpad_s1;
    logic [3:0] r_dpad_s2;
    logic [7:0] r_joy_x;
    logic [7:0] r_joy_y;
    logic [3:0] r_stick;
    logic [3:0] w_stick_nxt;
    logic [3:0] w_raw_dir;
    logic [3:0] w_resolved;
    logic [3:0] r_dir_held;
    logic [3:0] w_dir_pulse;
    logic [8:0] w_x;
    logic [8:0] w_y;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_buttons = {gc.Z, gc.start_pause, gc.Y, gc.X, gc.B, gc.A};
    assign w_dpad    = {gc.D_UP, gc.D_DOWN, gc.D_LEFT, gc.D_RIGHT};

    // Stage 1: sample raw receiver levels; press pulses derive from held levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_held  <= '0;
            r_btn_prev  <= '0;
            r_btn_press <= '0;
            r_dpad_s1   <= '0;
            r_joy_x     <= '0;
            r_joy_y     <= '0;
        end else begin
            r_btn_held  <= w_buttons;
            r_btn_prev  <= r_btn_held;
            r_btn_press <= r_btn_held & ~r_btn_prev;
            r_dpad_s1   <= w_dpad;
            r_joy_x     <= gc.JOY_X;
            r_joy_y     <= gc.JOY_Y;
        end
    end

    // Widened to 9 bits so center +/- deadzone never wraps.
    assign w_x = {1'b0, r_joy_x};
    assign w_y = {1'b0, r_joy_y};

    assign w_stick_nxt[0] = hyst(r_stick[0], w_x >= c_hi_on,          w_x < c_hi_off);
    assign w_stick_nxt[1] = hyst(r_stick[1], (w_x + c_on) <= c_center, (w_x + c_off) > c_center);
    assign w_stick_nxt[2] = hyst(r_stick[2], (w_y + c_on) <= c_center, (w_y + c_off) > c_center);
    assign w_stick_nxt[3] = hyst(r_stick[3], w_y >= c_hi_on,          w_y < c_hi_off);

    // Stage 2: D-pad is delayed alongside the stick flags so both sources line up.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stick   <= '0;
            r_dpad_s2 <= '0;
        end else begin
            r_stick   <= w_stick_nxt;
            r_dpad_s2 <= r_dpad_s1;
        end
    end

    assign w_raw_dir = r_dpad_s2 | r_stick;

    always_comb begin
        w_resolved = w_raw_dir;
        if (w_raw_dir[3] && w_raw_dir[2]) w_resolved[3:2] = 2'b00;
        if (w_raw_dir[1] && w_raw_dir[0]) w_resolved[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir_held <= '0;
        end else begin
            r_dir_held <= w_resolved;
        end
    end

    // Free-running repeat timebase, shared by all directions.
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_dir
        dir_state_t         r_state;
        dir_state_t         w_state_nxt;
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_cnt_w-1:0] w_cnt_nxt;
        logic [c_cnt_w-1:0] w_cnt_inc;
        logic               r_pulse;
        logic               w_pulse_nxt;

        assign w_cnt_inc = r_cnt + c_cnt_one;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // A dropped level always returns to IDLE, even on a due repeat.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_pulse_nxt = 1'b0;
            if (!r_dir_held[i]) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (w_tick) begin
                            if (w_cnt_inc == c_delay) begin
                                w_pulse_nxt = 1'b1;
                                w_cnt_nxt   = '0;
                                w_state_nxt = ST_REPEAT;
                            end else begin
                                w_cnt_nxt = w_cnt_inc;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (w_tick) begin
                            if (w_cnt_inc == c_rate) begin
                                w_pulse_nxt = 1'b1;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_cnt_nxt = w_cnt_inc;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign w_dir_pulse[i] = r_pulse;
    end

    assign gc.btn_held  = r_btn_held;
    assign gc.btn_press = r_btn_press;
    assign gc.dir_held  = r_dir_held;
    assign gc.dir_pulse = w_dir_pulse;

endmodule
`default_nettype wire

// File: tb/tb_gc_input_conditioner.sv
`default_nettype none
// ============================================================================
//  tb_gc_input_conditioner
//  Directed self-checking bench: buttons, hysteresis, conflict, auto-repeat.
//  Revision: 1.0
// ============================================================================
module tb_gc_input_conditioner;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    gc_input_conditioner_if gc_if ();

    gc_input_conditioner #(
        .TICK_CYCLES  (10),
        .DEADZONE_ON  (40),
        .DEADZONE_OFF (24),
        .REPEAT_DELAY (3),
        .REPEAT_RATE  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .gc    (gc_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until dir_pulse[b] is seen; n = steps taken, -1 if never seen.
    task automatic wait_pulse(input int b, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!gc_if.dir_pulse[b] && n < limit);
        if (!gc_if.dir_pulse[b]) n = -1;
    endtask

    task automatic count_dir(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (gc_if.dir_pulse != 4'b0000) pulses++;
        end
    endtask

    task automatic count_btn(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (gc_if.btn_press != 6'b000000) pulses++;
        end
    endtask

    initial begin
        int n;
        int p;

        gc_if.A = 1'b1;  gc_if.B = 1'b0;  gc_if.X = 1'b0;  gc_if.Y = 1'b0;
        gc_if.start_pause = 1'b0;  gc_if.Z = 1'b0;
        gc_if.D_UP = 1'b0;  gc_if.D_DOWN = 1'b0;  gc_if.D_LEFT = 1'b0;  gc_if.D_RIGHT = 1'b0;
        gc_if.JOY_X = 8'd128;  gc_if.JOY_Y = 8'd128;

        // Reset with A held
        repeat (3) step();
        check("rst_btn_held",  gc_if.btn_held,  6'b000000);
        check("rst_btn_press", gc_if.btn_press, 6'b000000);
        check("rst_dir_held",  gc_if.dir_held,  4'b0000);
        check("rst_dir_pulse", gc_if.dir_pulse, 4'b0000);
        reset = 1'b0;
        step();
        check("a_held_e1",  gc_if.btn_held,  6'b000001);
        check("a_press_e1", gc_if.btn_press, 6'b000000);
        step();
        check("a_press_e2", gc_if.btn_press, 6'b000001);
        step();
        check("a_press_e3", gc_if.btn_press, 6'b000000);
        check("a_held_e3",  gc_if.btn_held,  6'b000001);
        gc_if.A = 1'b0;
        count_btn(5, p);
        check("a_release_no_press", p, 0);
        check("a_release_held", gc_if.btn_held, 6'b000000);

        // Two buttons together
        gc_if.B = 1'b1;  gc_if.Z = 1'b1;
        step();
        step();
        check("bz_press", gc_if.btn_press, 6'b100010);
        step();
        check("bz_press_end", gc_if.btn_press, 6'b000000);
        gc_if.B = 1'b0;  gc_if.Z = 1'b0;
        repeat (3) step();

        // D_RIGHT hold with auto-repeat
        gc_if.D_RIGHT = 1'b1;
        repeat (3) step();
        check("dr_held",      gc_if.dir_held,  4'b0001);
        check("dr_pre_pulse", gc_if.dir_pulse, 4'b0000);
        step();
        check("dr_first", gc_if.dir_pulse, 4'b0001);
        wait_pulse(0, 40, n);
        check("dr_first_repeat_window", (n >= 21 && n <= 30), 1);
        for (int k = 0; k < 3; k++) begin
            wait_pulse(0, 40, n);
            check("dr_repeat_gap", n, 20);
        end
        gc_if.D_RIGHT = 1'b0;
        count_dir(40, p);
        check("dr_release_no_pulse", p, 0);
        check("dr_release_held", gc_if.dir_held, 4'b0000);

        // Stick X hysteresis
        gc_if.JOY_X = 8'd167;
        count_dir(6, p);
        check("jx167_no_set", {p[3:0], gc_if.dir_held}, 8'h00);
        gc_if.JOY_X = 8'd168;
        count_dir(6, p);
        check("jx168_one_pulse", p, 1);
        check("jx168_held", gc_if.dir_held, 4'b0001);
        for (int v = 167; v >= 152; v--) begin
            gc_if.JOY_X = 8'(v);
            repeat (2) step();
        end
        check("jx152_still_held", gc_if.dir_held, 4'b0001);
        gc_if.JOY_X = 8'd151;
        repeat (4) step();
        check("jx151_clear", gc_if.dir_held, 4'b0000);
        gc_if.JOY_X = 8'd167;
        count_dir(6, p);
        check("jx167_from_clear", {p[3:0], gc_if.dir_held}, 8'h00);

        // Left boundary and Y axis
        gc_if.JOY_X = 8'd89;
        count_dir(6, p);
        check("jx89_no_left", gc_if.dir_held, 4'b0000);
        gc_if.JOY_X = 8'd88;
        count_dir(6, p);
        check("jx88_left", gc_if.dir_held, 4'b0010);
        gc_if.JOY_X = 8'd128;
        repeat (4) step();
        gc_if.JOY_Y = 8'd168;
        repeat (6) step();
        check("jy168_up", gc_if.dir_held, 4'b1000);
        gc_if.JOY_Y = 8'd88;
        repeat (6) step();
        check("jy88_down", gc_if.dir_held, 4'b0100);
        gc_if.JOY_Y = 8'd128;
        repeat (4) step();
        check("jy_center", gc_if.dir_held, 4'b0000);
        repeat (4) step();

        // Left stick against D_RIGHT
        gc_if.JOY_X = 8'd20;  gc_if.D_RIGHT = 1'b1;
        count_dir(10, p);
        check("conflict_no_pulse", p, 0);
        check("conflict_held", gc_if.dir_held, 4'b0000);
        gc_if.D_RIGHT = 1'b0;
        repeat (3) step();
        check("conflict_left_held", gc_if.dir_held, 4'b0010);
        step();
        check("conflict_left_pulse", gc_if.dir_pulse, 4'b0010);
        gc_if.JOY_X = 8'd128;
        repeat (6) step();

        // Release on the same cycle a repeat is due
        gc_if.D_UP = 1'b1;
        wait_pulse(3, 8, n);
        check("up_first_latency", n, 4);
        wait_pulse(3, 40, n);
        check("up_first_repeat_window", (n >= 21 && n <= 30), 1);
        repeat (16) step();
        gc_if.D_UP = 1'b0;
        count_dir(30, p);
        check("up_release_on_due", p, 0);
        gc_if.D_UP = 1'b1;
        repeat (3) step();
        check("up_repress_early", gc_if.dir_pulse, 4'b0000);
        step();
        check("up_repress_first", gc_if.dir_pulse, 4'b1000);
        gc_if.D_UP = 1'b0;
        repeat (6) step();

        // Reset in the middle of REPEAT with stick up
        gc_if.JOY_Y = 8'd255;
        wait_pulse(3, 8, n);
        check("y255_first", n, 4);
        wait_pulse(3, 40, n);
        check("y255_repeat_window", (n >= 21 && n <= 30), 1);
        repeat (5) step();
        reset = 1'b1;
        step();
        check("rst2_outputs", {gc_if.btn_held, gc_if.btn_press, gc_if.dir_held, gc_if.dir_pulse}, 20'h0);
        step();
        step();
        check("rst2_outputs_late", {gc_if.btn_held, gc_if.btn_press, gc_if.dir_held, gc_if.dir_pulse}, 20'h0);
        reset = 1'b0;
        wait_pulse(3, 8, n);
        check("rst2_first_latency", n, 4);
        wait_pulse(3, 40, n);
        check("rst2_fresh_delay", n, 26);
        wait_pulse(3, 40, n);
        check("rst2_repeat_gap", n, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gc_input_conditioner.md
Name: gc_input_conditioner

Overview:
- Sits directly downstream of the GameCube controller receiver.
- Consumes the receiver's raw button levels and 8-bit analog stick values, and turns them into game-ready events for the arcade game logic.
- Button events are single-cycle press pulses plus held levels.
- Direction events merge the D-pad with the main stick, using a hysteretic deadzone and menu-style auto-repeat.

Parameters:
- TICK_CYCLES, 100000: clk cycles per repeat tick (1 ms at 100 MHz).
- DEADZONE_ON, 40: stick distance from center 128 needed to assert a direction.
- DEADZONE_OFF, 24: stick distance from center below which an asserted direction releases. Must be < DEADZONE_ON.
- REPEAT_DELAY, 300: ticks from the first direction pulse to the first repeat pulse.
- REPEAT_RATE, 100: ticks between subsequent repeat pulses.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- A, B, X, Y, start_pause, Z  in  1 each  raw button levels from the receiver, 1 = pressed
- D_UP, D_DOWN, D_LEFT, D_RIGHT  in  1 each  raw D-pad levels
- JOY_X, JOY_Y  in  8 each  unsigned stick position, 128 = center, larger Y = up
- btn_held  out  6  registered button levels {Z, start_pause, Y, X, B, A}
- btn_press  out  6  one-cycle rising-edge pulses, same bit order
- dir_held  out  4  merged direction levels {up, down, left, right}
- dir_pulse  out  4  one-cycle direction event pulses (first press + auto-repeat), same order

Behaviour:
- Single clock, synchronous active-high reset. All state updates on posedge clk.
- Reset: all outputs 0, all sample/previous registers 0, stick hysteresis flags 0, tick counter 0, all direction FSMs IDLE.
- A button or direction held through reset produces a press/first pulse after reset deasserts.
- Input register: every cycle, btn_held <= buttons and raw D-pad/stick values are registered.
- btn_press[i] <= btn_held[i] & ~prev[i], with prev <= btn_held. A rise seen at edge N gives btn_press high for the single cycle after edge N+1. Fall gives no pulse.
- Stick hysteresis, per axis flag, evaluated on the registered values:
  - right sets when JOY_X >= 128+DEADZONE_ON; clears when JOY_X < 128+DEADZONE_OFF; otherwise holds.
  - left sets when JOY_X <= 128-DEADZONE_ON; clears when JOY_X > 128-DEADZONE_OFF; otherwise holds.
  - up and down use JOY_Y in the same way.
  - Compares use 9-bit unsigned arithmetic; no wrap.
- Merged level raw_dir = D-pad | stick flag.
- Opposing conflict: if up and down are both raw-set, both are forced 0; same for left/right. dir_held is the conflict-resolved level, registered one cycle after the flags.
- Tick counter runs free 0..TICK_CYCLES-1. tick is high for one cycle when count == TICK_CYCLES-1, then the count wraps to 0. The counter is never cleared by direction activity.
- Per-direction FSM, 4 independent instances, each with a repeat counter of width ceil(log2(max(REPEAT_DELAY, REPEAT_RATE)+1)):
  - IDLE: on dir_held rising, pulse dir_pulse for one cycle, cnt <= 0, go to DELAY.
  - DELAY: on tick, cnt++. When cnt reaches REPEAT_DELAY, pulse, cnt <= 0, go to REPEAT.
  - REPEAT: on tick, cnt++. When cnt reaches REPEAT_RATE, pulse, cnt <= 0.
  - Any state: dir_held low forces IDLE, cnt <= 0, no pulse. This wins over a simultaneous tick or count match.
  - Because the tick is free-running, the first-to-repeat interval is REPEAT_DELAY ticks, within -1 tick of jitter.
- Disconnect: the receiver zeros buttons and centers the sticks. All levels fall, so no pulses are generated, and the FSMs return to IDLE.
- Pulses are never merged or queued. Each pulse is exactly one cycle wide.

Test Plan (bench parameters TICK_CYCLES=10, REPEAT_DELAY=3, REPEAT_RATE=2, deadzones 40/24):
- Reset with A=1 held, then release reset → btn_held[0]=1 after the first edge, btn_press[0] high exactly one cycle, then 0 while A stays held. Dropping A produces no pulse.
- Hold D_RIGHT for 100 cycles → dir_pulse[0] at rise, again 21–30 cycles later, then every 20 cycles. Releasing D_RIGHT stops pulses immediately.
- Sweep JOY_X 128→168 → right set at 168. Ramp 168→152 → still set. 151 → clears. 167 → does not set from the cleared state.
- JOY_X=20 with D_RIGHT=1 → left and right conflict, dir_held[1:0]=00, no pulses. Removing D_RIGHT gives a left first pulse.
- Direction held in REPEAT, released in the same cycle a repeat is due → no pulse that cycle, FSM IDLE. Re-press gives an immediate first pulse.
- Assert reset mid-REPEAT with JOY_Y=255 → all outputs 0 during reset. After release, up first pulse and a fresh REPEAT_DELAY interval.
